// File: rtl/ddr_write_ctrl_if.sv
// ddr_write_ctrl_if
//   Memory-controller user (app) interface used by the DDR write adapter.
//   One write command plus one write-data word per beat.
//   master : the write adapter (drives command/data, receives ready)
//   slave  : the memory controller (receives command/data, drives ready)
//   Signals:
//     app_en / app_cmd / app_addr           command valid, opcode, address
//     app_rdy                               command accepted when app_en && app_rdy
//     app_wdf_wren / app_wdf_end / app_wdf_data  write-data valid, last word, data
//     app_wdf_rdy                           data accepted when app_wdf_wren && app_wdf_rdy
interface ddr_write_ctrl_if #(
    parameter int DW = 512,
    parameter int AW = 30
);
    logic          app_en;
    logic [2:0]    app_cmd;
    logic [AW-1:0] app_addr;
    logic          app_rdy;
    logic          app_wdf_wren;
    logic          app_wdf_end;
    logic [DW-1:0] app_wdf_data;
    logic          app_wdf_rdy;

    modport master (
        output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data,
        input  app_rdy, app_wdf_rdy
    );

    modport slave (
        input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data,
        output app_rdy, app_wdf_rdy
    );
endinterface

// File: rtl/ddr_write_ctrl.sv
// ddr_write_ctrl
//   Single-channel DDR write adapter. Accepts a level-held burst request,
//   pulls 512-bit beats from the client one at a time and issues one write
//   command plus one write-data word per beat on the app interface. A
//   single-cycle done pulse follows acceptance of the last beat.
//   Ports:
//     clk_i, rstn_i            clock, asynchronous active-low reset
//     init_calib_complete_i    controller calibrated (checked only in IDLE)
//     wr_ddr_en_i              request, held high until done is seen
//     wr_burst_num_i           beats in burst (0 means 1), sampled at first beat
//     wr_start_addr_i          first-beat address, sampled at request accept
//     wr_data_i                beat data, valid one cycle after fetch_data_en_o
//     fetch_data_en_o          one-cycle strobe requesting the next beat
//     wr_ddr_done_o            one-cycle pulse when all beats are accepted
//     app                      app command/data interface (master side)
module ddr_write_ctrl #(
    parameter int DW        = 512,
    parameter int AW        = 30,
    parameter int ADDR_STEP = 8
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          init_calib_complete_i,
    input  logic          wr_ddr_en_i,
    input  logic [4:0]    wr_burst_num_i,
    input  logic [AW-1:0] wr_start_addr_i,
    input  logic [DW-1:0] wr_data_i,
    output logic          fetch_data_en_o,
    output logic          wr_ddr_done_o,
    ddr_write_ctrl_if.master app
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CAPTURE  = 2'd1,
        S_ISSUE    = 2'd2,
        S_WAIT_LOW = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [5:0]    beat_cnt_q, beat_cnt_d;
    logic [4:0]    len_q, len_d;
    logic          cmd_ok_q, cmd_ok_d;
    logic          dat_ok_q, dat_ok_d;
    logic          fetch_q, fetch_d;
    logic          done_q, done_d;
    logic          app_en_q, app_en_d;
    logic          wren_q, wren_d;
    logic [AW-1:0] app_addr_q, app_addr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic       accept;
    logic       cmd_done, dat_done, beat_done;
    logic [5:0] beat_cnt_inc;
    logic       last_beat;

    assign accept       = wr_ddr_en_i && init_calib_complete_i;
    // A handshake in the current cycle counts the same as one already recorded.
    assign cmd_done     = cmd_ok_q || (app_en_q && app.app_rdy);
    assign dat_done     = dat_ok_q || (wren_q && app.app_wdf_rdy);
    assign beat_done    = cmd_done && dat_done;
    assign beat_cnt_inc = beat_cnt_q + 6'd1;
    assign last_beat    = (beat_cnt_inc == {1'b0, len_q});

    // State and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            beat_cnt_q <= '0;
            len_q      <= '0;
            cmd_ok_q   <= 1'b0;
            dat_ok_q   <= 1'b0;
            fetch_q    <= 1'b0;
            done_q     <= 1'b0;
            app_en_q   <= 1'b0;
            wren_q     <= 1'b0;
            app_addr_q <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            cmd_ok_q   <= cmd_ok_d;
            dat_ok_q   <= dat_ok_d;
            fetch_q    <= fetch_d;
            done_q     <= done_d;
            app_en_q   <= app_en_d;
            wren_q     <= wren_d;
            app_addr_q <= app_addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (accept) state_d = S_CAPTURE;
            // The strobe cycle waits; the beat appears on wr_data_i the cycle after.
            S_CAPTURE:  if (!fetch_q) state_d = S_ISSUE;
            S_ISSUE:    if (beat_done) state_d = last_beat ? S_WAIT_LOW : S_CAPTURE;
            S_WAIT_LOW: if (!wr_ddr_en_i) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Registered-output and datapath next values.
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        addr_d     = addr_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        cmd_ok_d   = cmd_ok_q;
        dat_ok_d   = dat_ok_q;
        fetch_d    = 1'b0;
        done_d     = 1'b0;
        app_en_d   = 1'b0;
        wren_d     = 1'b0;
        app_addr_d = app_addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d     = wr_start_addr_i;
                    beat_cnt_d = '0;
                    fetch_d    = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (!fetch_q) begin
                    wdata_d = wr_data_i;
                    if (beat_cnt_q == '0)
                        len_d = (wr_burst_num_i == '0) ? 5'd1 : wr_burst_num_i;
                    app_addr_d = addr_q;
                    app_en_d   = 1'b1;
                    wren_d     = 1'b1;
                    cmd_ok_d   = 1'b0;
                    dat_ok_d   = 1'b0;
                end
            end
            S_ISSUE: begin
                app_en_d = app_en_q && !app.app_rdy;
                wren_d   = wren_q && !app.app_wdf_rdy;
                cmd_ok_d = cmd_done;
                dat_ok_d = dat_done;
                if (beat_done) begin
                    beat_cnt_d = beat_cnt_inc;
                    addr_d     = addr_q + AW'(ADDR_STEP);
                    if (last_beat) done_d  = 1'b1;
                    else           fetch_d = 1'b1;
                end
            end
            S_WAIT_LOW: ;
            default: begin
                addr_d     = '0;
                beat_cnt_d = '0;
                len_d      = '0;
                cmd_ok_d   = 1'b0;
                dat_ok_d   = 1'b0;
                app_addr_d = '0;
                wdata_d    = '0;
            end
        endcase
    end

    assign fetch_data_en_o  = fetch_q;
    assign wr_ddr_done_o    = done_q;
    assign app.app_en       = app_en_q;
    assign app.app_cmd      = 3'b000;
    assign app.app_addr     = app_addr_q;
    assign app.app_wdf_wren = wren_q;
    assign app.app_wdf_end  = wren_q;
    assign app.app_wdf_data = wdata_q;

endmodule
